// File: rtl/ch2_38decoder_hold_pkg.sv
// ---------------------------------------------------------------------------
// ch2_dec_pkg
// Shared definitions for the chapter-2 3:8 decoder with output hold.
//   - state_t   : FSM state encoding (ST_IDLE / ST_HOLD)
//   - onehot()  : binary code -> one-hot word, computed over a fixed maximum
//                 width so that callers can size-cast to their own OUT_W.
// ---------------------------------------------------------------------------
package ch2_dec_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // The decoder supports code widths up to ONEHOT_MAX_IN_W bits.
    localparam int ONEHOT_MAX_IN_W  = 5;
    localparam int ONEHOT_MAX_OUT_W = 2 ** ONEHOT_MAX_IN_W;

    // 1 << code. Every code value is legal, so there is no out-of-range case.
    function automatic logic [ONEHOT_MAX_OUT_W-1:0] onehot(
        input logic [ONEHOT_MAX_IN_W-1:0] code
    );
        return {{(ONEHOT_MAX_OUT_W-1){1'b0}}, 1'b1} << code;
    endfunction

endpackage

// File: rtl/ch2_38decoder_hold_if.sv
// ---------------------------------------------------------------------------
// ch2_38decoder_hold_if
// Input handshake plus held one-hot output of the 3:8 decoder.
//   EN       block enable (low aborts any active hold)
//   I        binary code, qualified by I_VALID
//   I_READY  decoder can take I this cycle
//   O        one-hot output, zero when nothing is held
//   O_VALID  O carries a held word
//   BUSY     decoder FSM is in HOLD
// master = the side supplying codes; slave = the decoder.
// ---------------------------------------------------------------------------
interface ch2_38decoder_hold_if #(
    parameter int IN_W = 3
) ();
    localparam int OUT_W = 2 ** IN_W;

    logic              EN;
    logic [IN_W-1:0]   I;
    logic              I_VALID;
    logic              I_READY;
    logic [OUT_W-1:0]  O;
    logic              O_VALID;
    logic              BUSY;

    modport master (
        output EN,
        output I,
        output I_VALID,
        input  I_READY,
        input  O,
        input  O_VALID,
        input  BUSY
    );

    modport slave (
        input  EN,
        input  I,
        input  I_VALID,
        output I_READY,
        output O,
        output O_VALID,
        output BUSY
    );
endinterface

// File: rtl/ch2_38decoder_hold_counter.sv
// ---------------------------------------------------------------------------
// ch2_hold_counter
// Down-counter that times how long a decoded word stays on the output.
//   clk, rst  clock / asynchronous active-high reset (count -> 0)
//   clr       force count to 0 (used when a hold is aborted)
//   load      load HOLD-1 (start of a new hold window)
//   dec       count down by one, saturating at 0
//   zero      count is 0 (last cycle of the hold window)
// Priority: clr > load > dec.
// ---------------------------------------------------------------------------
module ch2_hold_counter #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic dec,
    output logic zero
);
    // With HOLD=1 the load value is 0 and a 1-bit register is still kept.
    localparam int                 CNT_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0]   LOAD_VAL = CNT_W'(HOLD - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ch2_38decoder_hold.sv
// ---------------------------------------------------------------------------
// ch2_38decoder_hold
// Registered 3-to-8 one-hot decoder with valid/ready input and a timed hold.
// An accepted code appears on O on the accepting edge and stays there for
// exactly HOLD cycles, then O returns to zero unless a new code is accepted
// in the last hold cycle (back-to-back, no gap).
// Ports:
//   CLK   clock, rising edge
//   RST   asynchronous active-high reset
//   bus   slave side of ch2_38decoder_hold_if (EN, I, I_VALID, I_READY,
//         O, O_VALID, BUSY)
// Parameters:
//   IN_W  code width (<= ch2_dec_pkg::ONEHOT_MAX_IN_W); OUT_W = 2**IN_W
//   HOLD  cycles each word is held, >= 1
// ---------------------------------------------------------------------------
module ch2_38decoder_hold
    import ch2_dec_pkg::*;
#(
    parameter int IN_W = 3,
    parameter int HOLD = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    ch2_38decoder_hold_if.slave    bus
);
    localparam int OUT_W = 2 ** IN_W;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   o_q, o_d;
    logic               ov_q, ov_d;
    logic               cnt_zero;
    logic               cnt_clr, cnt_load, cnt_dec;
    logic               ready;
    logic               xfer;
    logic [OUT_W-1:0]   code_onehot;

    // Ready in IDLE, or in the last hold cycle so a new word follows with no gap.
    // Reset forces IDLE, so I_READY follows EN while RST is high.
    assign ready = bus.EN & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & cnt_zero));
    assign xfer  = bus.I_VALID & ready;

    assign code_onehot = OUT_W'(onehot(ONEHOT_MAX_IN_W'(bus.I)));

    ch2_hold_counter #(
        .HOLD (HOLD)
    ) u_hold_counter (
        .clk  (CLK),
        .rst  (RST),
        .clr  (cnt_clr),
        .load (cnt_load),
        .dec  (cnt_dec),
        .zero (cnt_zero)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; EN-low abort outranks transfer, transfer outranks count
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!bus.EN) begin
                    state_d = ST_IDLE;
                end else if (!cnt_zero) begin
                    state_d = ST_HOLD;
                end else if (xfer) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / counter-control logic
    always_comb begin
        o_d      = o_q;
        ov_d     = ov_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    o_d      = code_onehot;
                    ov_d     = 1'b1;
                    cnt_load = 1'b1;
                end else begin
                    o_d  = '0;
                    ov_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (!bus.EN) begin
                    o_d     = '0;
                    ov_d    = 1'b0;
                    cnt_clr = 1'b1;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (xfer) begin
                    o_d      = code_onehot;
                    ov_d     = 1'b1;
                    cnt_load = 1'b1;
                end else begin
                    o_d  = '0;
                    ov_d = 1'b0;
                end
            end
            default: begin
                o_d  = '0;
                ov_d = 1'b0;
            end
        endcase
    end

    // Output register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_q  <= '0;
            ov_q <= 1'b0;
        end else begin
            o_q  <= o_d;
            ov_q <= ov_d;
        end
    end

    assign bus.I_READY = ready;
    assign bus.O       = o_q;
    assign bus.O_VALID = ov_q;
    assign bus.BUSY    = (state_q == ST_HOLD);

endmodule

// File: tb/tb_ch2_38decoder_hold.sv
// ---------------------------------------------------------------------------
// tb_ch2_38decoder_hold
// Directed bench for ch2_38decoder_hold: one instance with HOLD=4 and one
// with HOLD=1 sharing CLK/RST. Inputs change and outputs are sampled 1 time
// unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_ch2_38decoder_hold;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    ch2_38decoder_hold_if #(.IN_W(3)) bus4 ();
    ch2_38decoder_hold_if #(.IN_W(3)) bus1 ();

    ch2_38decoder_hold #(.IN_W(3), .HOLD(4)) dut4 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus4.slave)
    );

    ch2_38decoder_hold #(.IN_W(3), .HOLD(1)) dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus1.slave)
    );

    // Independent 8:3 encoder (the loopback partner), highest set bit wins.
    function automatic logic [2:0] enc83(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int b = 0; b < 8; b++) begin
            if (v[b]) r = 3'(b);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        bus4.EN = 1'b1; bus4.I = 3'd0; bus4.I_VALID = 1'b0;
        bus1.EN = 1'b1; bus1.I = 3'd0; bus1.I_VALID = 1'b0;
        RST = 1'b1;
        step();
        vectors++;
        if (bus4.O !== 8'h00 || bus4.O_VALID !== 1'b0 || bus4.BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: O=%h O_VALID=%b BUSY=%b, need 00/0/0", bus4.O, bus4.O_VALID, bus4.BUSY);
        end
        vectors++;
        if (bus4.I_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready_follows_en: I_READY=%b, need 1", bus4.I_READY);
        end
        RST = 1'b0;
        // start a hold of I=5, then hit reset mid-hold
        bus4.I = 3'd5; bus4.I_VALID = 1'b1;
        step();
        bus4.I_VALID = 1'b0;
        vectors++;
        if (bus4.O !== 8'h20) begin
            miscompares++;
            $display("FAIL reset_pre_load: O=%h, need 20", bus4.O);
        end
        step();
        #2;
        RST = 1'b1;
        #1;
        vectors++;
        if (bus4.O !== 8'h00 || bus4.O_VALID !== 1'b0 || bus4.BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async_clear: O=%h O_VALID=%b BUSY=%b, need 00/0/0", bus4.O, bus4.O_VALID, bus4.BUSY);
        end
        step();
        RST = 1'b0;
        step();
        vectors++;
        if (bus4.I_READY !== 1'b1 || bus4.O !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_release: I_READY=%b O=%h, need 1/00", bus4.I_READY, bus4.O);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp;
        for (int c = 0; c < 8; c++) begin
            exp = 8'h01 << c;
            bus4.I = 3'(c); bus4.I_VALID = 1'b1;
            step();
            bus4.I_VALID = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (k != 0) step();
                vectors++;
                if (bus4.O !== exp || bus4.O_VALID !== 1'b1 || bus4.BUSY !== 1'b1) begin
                    miscompares++;
                    $display("FAIL sweep_hold code=%0d cyc=%0d: O=%h OV=%b BUSY=%b, need %h/1/1", c, k, bus4.O, bus4.O_VALID, bus4.BUSY, exp);
                end
                vectors++;
                if (bus4.I_READY !== (k == 3)) begin
                    miscompares++;
                    $display("FAIL sweep_ready code=%0d cyc=%0d: I_READY=%b, need %b", c, k, bus4.I_READY, (k == 3));
                end
            end
            step();
            vectors++;
            if (bus4.O !== 8'h00 || bus4.O_VALID !== 1'b0 || bus4.BUSY !== 1'b0) begin
                miscompares++;
                $display("FAIL sweep_clear code=%0d: O=%h OV=%b BUSY=%b, need 00/0/0", c, bus4.O, bus4.O_VALID, bus4.BUSY);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus4.I = 3'd3; bus4.I_VALID = 1'b1;
        step();
        bus4.I = 3'd5;   // stays valid; must wait for the last hold cycle
        for (int k = 0; k < 4; k++) begin
            if (k != 0) step();
            vectors++;
            if (bus4.O !== 8'h08) begin
                miscompares++;
                $display("FAIL b2b_first cyc=%0d: O=%h, need 08", k, bus4.O);
            end
        end
        step();
        bus4.I_VALID = 1'b0;
        vectors++;
        if (bus4.O !== 8'h20 || bus4.O_VALID !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second: O=%h OV=%b, need 20/1", bus4.O, bus4.O_VALID);
        end
        repeat (3) step();
        vectors++;
        if (bus4.O !== 8'h20) begin
            miscompares++;
            $display("FAIL b2b_second_last: O=%h, need 20", bus4.O);
        end
        step();
        vectors++;
        if (bus4.O !== 8'h00) begin
            miscompares++;
            $display("FAIL b2b_clear: O=%h, need 00", bus4.O);
        end
    endtask

    task automatic test_abort();
        bus4.I = 3'd6; bus4.I_VALID = 1'b1;
        step();
        bus4.I_VALID = 1'b0;
        step();
        vectors++;
        if (bus4.O !== 8'h40) begin
            miscompares++;
            $display("FAIL abort_pre: O=%h, need 40", bus4.O);
        end
        bus4.EN = 1'b0;
        #1;
        vectors++;
        if (bus4.I_READY !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_ready_low: I_READY=%b, need 0", bus4.I_READY);
        end
        step();
        vectors++;
        if (bus4.O !== 8'h00 || bus4.O_VALID !== 1'b0 || bus4.BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_clear: O=%h OV=%b BUSY=%b, need 00/0/0", bus4.O, bus4.O_VALID, bus4.BUSY);
        end
        bus4.I = 3'd1; bus4.I_VALID = 1'b1;   // must be ignored while EN=0
        step();
        vectors++;
        if (bus4.O !== 8'h00 || bus4.I_READY !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_disabled: O=%h I_READY=%b, need 00/0", bus4.O, bus4.I_READY);
        end
        bus4.I_VALID = 1'b0;
        bus4.EN = 1'b1;
        #1;
        vectors++;
        if (bus4.I_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_reenable: I_READY=%b, need 1", bus4.I_READY);
        end
        step();
    endtask

    task automatic test_hold1();
        logic [2:0] codes [3];
        logic [7:0] exps  [3];
        codes[0] = 3'd7; codes[1] = 3'd0; codes[2] = 3'd2;
        exps[0]  = 8'h80; exps[1] = 8'h01; exps[2] = 8'h04;
        bus1.I_VALID = 1'b1;
        for (int n = 0; n < 3; n++) begin
            bus1.I = codes[n];
            step();
            vectors++;
            if (bus1.O !== exps[n] || bus1.O_VALID !== 1'b1 || bus1.I_READY !== 1'b1) begin
                miscompares++;
                $display("FAIL hold1_stream n=%0d: O=%h OV=%b I_READY=%b, need %h/1/1", n, bus1.O, bus1.O_VALID, bus1.I_READY, exps[n]);
            end
        end
        bus1.I_VALID = 1'b0;
        step();
        vectors++;
        if (bus1.O !== 8'h00 || bus1.BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL hold1_clear: O=%h BUSY=%b, need 00/0", bus1.O, bus1.BUSY);
        end
    endtask

    task automatic test_loopback();
        for (int c = 0; c < 8; c++) begin
            bus4.I = 3'(c); bus4.I_VALID = 1'b1;
            step();
            bus4.I_VALID = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (k != 0) step();
                vectors++;
                if (enc83(bus4.O) !== 3'(c) || bus4.O_VALID !== 1'b1) begin
                    miscompares++;
                    $display("FAIL loopback code=%0d cyc=%0d: enc=%0d OV=%b, need %0d/1", c, k, enc83(bus4.O), bus4.O_VALID, c);
                end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_back_to_back();
        test_abort();
        test_hold1();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
